secure_cipher_pipe: RTL and testbench
=====================================

// Module: secure_cipher_pipe
// PURPOSE
//  Parametrised, pipelined key-gated encrypt/decrypt engine for the memory/register data path.
//  Data beats enter on a valid/ready stream and carry a per-beat mode bit.
//  A key FSM admits data only after the correct access key is presented.
//  Repeated wrong keys trigger a timed lockout. Output is a registered stream with latency 2.
// PARAMETERS
//  DATA_W      32      data path width (>=8)
//  KEY_W       16      access key width
//  KEY_VAL     16'h0032 key value that unlocks the block
//  OFFSET      9       additive constant, taken mod 2^DATA_W
//  XOR_MASK    2       XOR constant, DATA_W bits
//  ROT         3       rotate amount, 0 < ROT < DATA_W
//  MAX_FAIL    3       consecutive wrong keys that trigger lockout (>=1)
//  LOCK_CYCLES 256     lockout duration in clk cycles (>=1)
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         asynchronous reset, active-high
//  key_valid  in   1         key_in is presented this cycle
//  key_in     in   KEY_W     access key
//  lock       in   1         single-cycle pulse: return to LOCKED
//  in_valid   in   1         input beat valid
//  in_ready   out  1         block accepts a beat when in_valid && in_ready
//  in_data    in   DATA_W    input word
//  in_mode    in   1         1 = encrypt, 0 = decrypt
//  out_valid  out  1         output beat valid
//  out_ready  in   1         downstream accepts the beat
//  out_data   out  DATA_W    transformed word
//  out_mode   out  1         mode of the beat on out_data
//  unlocked   out  1         FSM is in UNLOCKED
//  lockout    out  1         FSM is in LOCKOUT
//  fail_cnt   out  $clog2(MAX_FAIL+1)  consecutive wrong-key count
// BEHAVIOUR
//  Reset (async, rst=1):
//   - FSM goes to LOCKED; both pipeline stages are invalidated.
//   - out_valid, out_data, out_mode, unlocked, lockout, fail_cnt and the lockout timer all = 0.
//  FSM states: LOCKED, UNLOCKED, LOCKOUT. Priority per cycle: rst > lock > key_valid.
//   - LOCKED: key_in==KEY_VAL -> UNLOCKED, fail_cnt=0.
//     Wrong key -> fail_cnt+1; when the count reaches MAX_FAIL -> LOCKOUT, fail_cnt=0, timer=LOCK_CYCLES.
//   - UNLOCKED: correct key is a no-op. Wrong key -> LOCKED with fail_cnt=1 (same MAX_FAIL rule).
//     lock=1 -> LOCKED with fail_cnt unchanged.
//   - LOCKOUT: key_valid and lock are ignored and not counted. Timer decrements each cycle.
//     lockout stays high exactly LOCK_CYCLES cycles, then state -> LOCKED.
//  Stream:
//   - in_ready = unlocked && (!s1_valid || s2_adv), where s2_adv = !out_valid || out_ready.
//   - Beats already in flight drain normally after leaving UNLOCKED; only new acceptance is blocked.
//   - s1 loads on accept. s2 (the output register) loads from s1 when s2_adv && s1_valid.
//   - Latency with no backpressure: a beat accepted at edge N is out_valid after edge N+1.
//   - Throughput: 1 beat/cycle. Order is preserved. No beat is lost or duplicated under any out_ready pattern.
//   - out_data and out_mode hold while out_valid && !out_ready.
//  Arithmetic (all mod 2^DATA_W; rotl/rotr by ROT):
//   - encrypt: s1 = (x + OFFSET) ^ XOR_MASK;  out = rotl(s1).
//   - decrypt: s1 = rotr(x) ^ XOR_MASK;      out = s1 - OFFSET.
//   - decrypt(encrypt(x)) == x for every x. Overflow and underflow wrap silently.
// TESTING (DATA_W=32, defaults)
//  1 Unlock and encrypt: key 0x0032; then encrypt 0x00000005 -> unlocked=1; out 0x00000060 two edges after accept.
//  2 Round trip and wrap: decrypt 0x00000060 -> 0x00000005. Encrypt 0xFFFFFFF8 -> 0x00000018. Decrypt 0x00000018 -> 0xFFFFFFF8.
//  3 Lockout: wrong keys 0x0001 x3 -> fail_cnt 1,2 then lockout=1 for 256 cycles with in_ready=0.
//    A 0x0032 key during lockout is ignored. After lockout, 0x0032 -> unlocked=1.
//  4 Backpressure: out_ready=0 for 6 cycles with 3 beats offered -> 2 accepted, in_ready=0.
//    On release, all 3 beats come out in order, back to back.
//  5 Relock in flight: lock pulse with 2 beats in the pipe -> in_ready=0 next cycle.
//    Both beats are still delivered. Simultaneous lock and key 0x0032 -> state LOCKED.
//  6 Async reset mid-stream: rst asserted between edges -> out_valid, unlocked, fail_cnt drop to 0 immediately.
//    No stale beat appears after reset is released.

Source files
------------

// File: rtl/secure_cipher_pipe.sv
// secure_cipher_pipe
//   Pipelined, key-gated encrypt/decrypt engine for the memory/register path.
//   A key FSM (LOCKED / UNLOCKED / LOCKOUT) gates admission of data beats.
//   Each beat carries its own mode bit and passes through two register
//   stages (s1, then the output register s2), so the latency is 2.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   key_valid, key_in   access key presented this cycle
//   lock                single-cycle pulse returning the FSM to LOCKED
//   in_valid/in_ready   input handshake; in_data word, in_mode 1=enc 0=dec
//   out_valid/out_ready output handshake; out_data word, out_mode its mode
//   unlocked, lockout   FSM status (registered)
//   fail_cnt            consecutive wrong-key count
module secure_cipher_pipe #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned KEY_W       = 16,
  parameter logic [KEY_W-1:0]  KEY_VAL  = 16'h0032,
  parameter int unsigned OFFSET      = 9,
  parameter logic [DATA_W-1:0] XOR_MASK = 2,
  parameter int unsigned ROT         = 3,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCK_CYCLES = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             key_valid,
  input  logic [KEY_W-1:0]                 key_in,
  input  logic                             lock,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_W-1:0]                in_data,
  input  logic                             in_mode,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_W-1:0]                out_data,
  output logic                             out_mode,
  output logic                             unlocked,
  output logic                             lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0]    fail_cnt
);

  localparam int unsigned FW = $clog2(MAX_FAIL + 1);
  localparam int unsigned TW = $clog2(LOCK_CYCLES + 1);

  localparam logic [DATA_W-1:0] OFF_W   = DATA_W'(OFFSET);
  localparam logic [FW-1:0]     FAIL_MAX = FW'(MAX_FAIL);
  localparam logic [TW-1:0]     LOCK_LEN = TW'(LOCK_CYCLES);
  localparam logic [TW-1:0]     TIMER_ONE = TW'(1);

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2
  } state_t;

  state_t          state;
  logic [TW-1:0]   lock_timer;

  // ---------------------------------------------------------------------------
  // Rotation helpers
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] v);
    return (v << ROT) | (v >> (DATA_W - ROT));
  endfunction

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] v);
    return (v >> ROT) | (v << (DATA_W - ROT));
  endfunction

  // ---------------------------------------------------------------------------
  // Key FSM
  // ---------------------------------------------------------------------------
  logic          key_ok;
  logic [FW-1:0] fail_base;
  logic [FW-1:0] fail_next;
  logic          fail_hit;

  // A wrong key from UNLOCKED restarts the count at 1, from LOCKED it
  // increments the running count; both use the same lockout threshold.
  always_comb begin
    key_ok    = (key_in == KEY_VAL);
    fail_base = (state == UNLOCKED) ? '0 : fail_cnt;
    fail_next = fail_base + FW'(1);
    fail_hit  = (fail_next == FAIL_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOCKED;
      fail_cnt   <= '0;
      lock_timer <= '0;
      unlocked   <= 1'b0;
      lockout    <= 1'b0;
    end else begin
      case (state)
        LOCKED, UNLOCKED: begin
          if (lock) begin
            // lock beats key_valid; fail_cnt is left as it is
            state    <= LOCKED;
            unlocked <= 1'b0;
          end else if (key_valid) begin
            if (key_ok) begin
              state    <= UNLOCKED;
              unlocked <= 1'b1;
              fail_cnt <= '0;
            end else if (fail_hit) begin
              state      <= LOCKOUT;
              unlocked   <= 1'b0;
              lockout    <= 1'b1;
              fail_cnt   <= '0;
              lock_timer <= LOCK_LEN;
            end else begin
              state    <= LOCKED;
              unlocked <= 1'b0;
              fail_cnt <= fail_next;
            end
          end
        end
        LOCKOUT: begin
          // The timer is loaded with LOCK_CYCLES on entry and the exit happens
          // on the edge where it reads 1, giving exactly LOCK_CYCLES cycles.
          if (lock_timer <= TIMER_ONE) begin
            state      <= LOCKED;
            lockout    <= 1'b0;
            lock_timer <= '0;
          end else begin
            lock_timer <= lock_timer - TIMER_ONE;
          end
        end
        default: begin
          state      <= LOCKED;
          unlocked   <= 1'b0;
          lockout    <= 1'b0;
          fail_cnt   <= '0;
          lock_timer <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Two-stage data pipeline
  // ---------------------------------------------------------------------------
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic              s1_mode;
  logic              s2_adv;
  logic              accept;
  logic [DATA_W-1:0] s1_next;
  logic [DATA_W-1:0] s2_next;

  always_comb begin
    s2_adv   = !out_valid || out_ready;
    in_ready = unlocked && (!s1_valid || s2_adv);
    accept   = in_valid && in_ready;
    s1_next  = in_mode ? ((in_data + OFF_W) ^ XOR_MASK)
                       : (rotr(in_data) ^ XOR_MASK);
    s2_next  = s1_mode ? rotl(s1_data) : (s1_data - OFF_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_data  <= s1_next;
      s1_mode  <= in_mode;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Output register holds its contents whenever it is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s2_next;
        out_mode <= s1_mode;
      end
    end
  end

endmodule

// File: tb/tb_secure_cipher_pipe.sv
module tb_secure_cipher_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [15:0] key_in;
  logic        lock;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_mode;
  logic        unlocked;
  logic        lockout;
  logic [1:0]  fail_cnt;

  int total = 0;
  int bad   = 0;

  secure_cipher_pipe dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_in(key_in), .lock(lock),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mode(out_mode), .unlocked(unlocked), .lockout(lockout), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  // Reference transforms written with plain modular arithmetic.
  localparam longint unsigned M32 = 64'h1_0000_0000;

  function automatic logic [31:0] enc_ref(input logic [31:0] x);
    longint unsigned t;
    t = (longint'(x) + 9) % M32;
    t = t ^ 2;
    t = ((t * 8) + (t / (M32 / 8))) % M32;
    return t[31:0];
  endfunction

  function automatic logic [31:0] dec_ref(input logic [31:0] x);
    longint unsigned t;
    t = ((longint'(x) / 8) + ((longint'(x) % 8) * (M32 / 8))) % M32;
    t = t ^ 2;
    t = (t + M32 - 9) % M32;
    return t[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [15:0] k);
    key_valid = 1'b1;
    key_in    = k;
    step();
    key_valid = 1'b0;
  endtask

  typedef struct {
    logic        mode;
    logic [31:0] din;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs[8];

  logic [31:0] qd[$];
  logic        qm[$];
  logic [31:0] beats[3];
  logic [31:0] expd;
  int          ptr;
  int          n;
  int          ir_seen;
  int          fail_seen;

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0005, 32'h0000_0060};
    vecs[1] = '{1'b0, 32'h0000_0060, 32'h0000_0005};
    vecs[2] = '{1'b1, 32'hFFFF_FFF8, 32'h0000_0018};
    vecs[3] = '{1'b0, 32'h0000_0018, 32'hFFFF_FFF8};
    vecs[4] = '{1'b1, 32'h0000_0000, 32'h0000_0058};
    vecs[5] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFF9};
    vecs[6] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0050};
    vecs[7] = '{1'b1, 32'h8000_0000, 32'h0000_005C};

    rst = 1'b1; key_valid = 1'b0; key_in = '0; lock = 1'b0;
    in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b0;
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data, 0);
    check("rst_out_mode",  out_mode, 0);
    check("rst_unlocked",  unlocked, 0);
    check("rst_lockout",   lockout, 0);
    check("rst_fail_cnt",  fail_cnt, 0);
    check("rst_in_ready",  in_ready, 0);
    rst = 1'b0;
    step();

    // Unlock, then the fixed vector table, one beat at a time.
    send_key(16'h0032);
    check("unlock", unlocked, 1);
    check("unlock_fail", fail_cnt, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = vecs[i].din; in_mode = vecs[i].mode;
      #1;
      check("vec_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      check("vec_lat_early", out_valid, 0);
      step();
      check("vec_valid", out_valid, 1);
      check("vec_data", out_data, vecs[i].dout);
      check("vec_mode", out_mode, vecs[i].mode);
      step();
    end

    // Random stream against a queue scoreboard.
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      in_mode   = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) begin
        qd.push_back(in_mode ? enc_ref(in_data) : dec_ref(in_data));
        qm.push_back(in_mode);
      end
      if (out_valid && out_ready) begin
        if (qd.size() == 0) check("rnd_extra_beat", 1, 0);
        else begin
          check("rnd_data", out_data, qd.pop_front());
          check("rnd_mode", out_mode, qm.pop_front());
        end
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (qd.size() != 0 && n < 20) begin
      #1;
      if (out_valid) begin
        check("rnd_drain_data", out_data, qd.pop_front());
        check("rnd_drain_mode", out_mode, qm.pop_front());
      end
      n++;
      step();
    end
    check("rnd_all_delivered", qd.size(), 0);
    step(); step();

    // Backpressure: 3 beats offered while the output is stalled.
    beats[0] = 32'h11; beats[1] = 32'h22; beats[2] = 32'h33;
    out_ready = 1'b0; ptr = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (ptr < 3); in_data = beats[ptr % 3]; in_mode = 1'b1;
      #1;
      if (in_valid && in_ready) ptr++;
      step();
    end
    check("bp_accepted", ptr, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_data", out_data, enc_ref(beats[0]));
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = (ptr < 3); in_data = beats[ptr % 3];
      #1;
      check("bp_b2b_valid", out_valid, 1);
      check("bp_b2b_data", out_data, enc_ref(beats[k]));
      if (in_valid && in_ready) ptr++;
      step();
    end
    in_valid = 1'b0;
    check("bp_total", ptr, 3);
    #1;
    check("bp_empty", out_valid, 0);
    step();

    // Relock with two beats in flight.
    out_ready = 1'b0;
    beats[0] = 32'hA0; beats[1] = 32'hB0;
    in_valid = 1'b1; in_data = beats[0]; in_mode = 1'b0; step();
    in_data = beats[1]; in_mode = 1'b1; step();
    in_valid = 1'b0; lock = 1'b1; step();
    lock = 1'b0;
    in_valid = 1'b1; in_data = 32'hC0;
    #1;
    check("relock_in_ready", in_ready, 0);
    check("relock_unlocked", unlocked, 0);
    out_ready = 1'b1; n = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid && out_ready) begin
        expd = (n == 0) ? dec_ref(beats[0]) : enc_ref(beats[1]);
        if (n < 2) check("relock_drain", out_data, expd);
        n++;
      end
      step();
    end
    in_valid = 1'b0;
    check("relock_count", n, 2);
    lock = 1'b1; key_valid = 1'b1; key_in = 16'h0032; step();
    lock = 1'b0; key_valid = 1'b0;
    check("lock_beats_key", unlocked, 0);

    // Lockout after MAX_FAIL wrong keys.
    send_key(16'h0001); check("fail1", fail_cnt, 1);
    send_key(16'h0001); check("fail2", fail_cnt, 2);
    check("fail2_no_lockout", lockout, 0);
    send_key(16'h0001);
    check("lockout_enter", lockout, 1);
    check("lockout_fail_clr", fail_cnt, 0);
    n = 0; ir_seen = 0; fail_seen = 0; in_valid = 1'b1;
    while (lockout && n < 1000) begin
      n++;
      key_valid = (n == 10 || n == 30); key_in = (n == 30) ? 16'h0001 : 16'h0032;
      lock = (n == 20);
      #1;
      if (in_ready) ir_seen++;
      if (fail_cnt != 0 || unlocked) fail_seen++;
      step();
    end
    key_valid = 1'b0; lock = 1'b0; in_valid = 1'b0;
    check("lockout_len", n, 256);
    check("lockout_in_ready", ir_seen, 0);
    check("lockout_keys_ignored", fail_seen, 0);
    check("post_lockout_locked", unlocked, 0);
    send_key(16'h0032);
    check("post_lockout_unlock", unlocked, 1);

    // Async reset in mid-stream.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h5; in_mode = 1'b1; step(); step();
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_unlocked", unlocked, 0);
    step(); rst = 1'b0; step();
    send_key(16'h0001);
    check("pre_rst_fail", fail_cnt, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_fail_cnt", fail_cnt, 0);
    step(); rst = 1'b0; step();
    send_key(16'h0032);
    out_ready = 1'b1; n = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid) n++;
      step();
    end
    check("no_stale_beat", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
